// File: rtl/mem_stage_pkg.sv
// Shared opcodes, width codes, fault codes, FSM encoding and the writeback
// result record used by the memory stage.
package mem_stage_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
   localparam logic [1:0] FAULT_FUNCT3   = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic [1:0]  fault;
   } wb_res_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the memory stage and the data memory.
interface mem_stage_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;

   modport master (output req, we, addr, be, wdata, input rdata, ack);
   modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: store byte enables / lane replication, legality
// and alignment checks, and load byte extraction with sign/zero extension.
module mem_stage_lsu_align
   import mem_stage_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  ea_lo,
   input  logic [31:0] sdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic        misalign,
   output logic        illegal,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_ea_lo,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   // Request side: width decode, enables and store lane replication
   always_comb begin
      be       = '0;
      wdata    = sdata;
      misalign = 1'b0;
      illegal  = 1'b1;
      case (funct3)
         F3_B: begin
            illegal = 1'b0;
            be      = 4'b0001 << ea_lo;
            wdata   = {4{sdata[7:0]}};
         end
         F3_H: begin
            illegal  = 1'b0;
            misalign = ea_lo[0];
            be       = ea_lo[1] ? 4'b1100 : 4'b0011;
            wdata    = {2{sdata[15:0]}};
         end
         F3_W: begin
            illegal  = 1'b0;
            misalign = |ea_lo;
            be       = 4'b1111;
         end
         F3_BU, F3_HU: begin
            // unsigned widths exist only for loads
            illegal  = is_store;
            misalign = (funct3 == F3_HU) & ea_lo[0];
         end
         default: ;
      endcase
      if (!is_store) be = '0;
   end

   // Response side: move the addressed lane to bit 0 and extend
   always_comb begin
      shifted = rdata >> {ld_ea_lo, 3'b000};
      case (ld_funct3)
         F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_W:    ld_data = shifted;
         F3_BU:   ld_data = {24'd0, shifted[7:0]};
         F3_HU:   ld_data = {16'd0, shifted[15:0]};
         default: ld_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM register and load/store unit: one req/ack transfer per memory op,
// a single registered writeback result, and an upstream stall while busy.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid_i,
   input  logic [6:0]  ex_opcode_i,
   input  logic [2:0]  ex_funct3_i,
   input  logic [4:0]  ex_wd_i,
   input  logic        ex_wreg_i,
   input  logic [31:0] ex_result_i,
   input  logic [31:0] ex_sdata_i,
   output logic        stall_o,
   mem_stage_if.master dmem,
   output logic        wb_valid_o,
   output logic [4:0]  wb_wd_o,
   output logic        wb_wreg_o,
   output logic [31:0] wb_wdata_o,
   output logic [1:0]  fault_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               pend_load_p1;
   logic [2:0]         pend_f3_p1;
   logic [1:0]         pend_ea_lo_p1;
   logic [4:0]         pend_wd_p1;
   logic               pend_wreg_p1;
   logic               hold_vld_p1;
   wb_res_t            hold_p1;

   logic        is_load, is_store, is_mem, accept, xfer_done, tmo;
   logic        issue, imm_vld, mem_fault, misalign, illegal;
   logic [3:0]  be;
   logic [31:0] wdata, ld_data;
   wb_res_t     imm_res, mem_res, wb_next, hold_next;
   logic        wb_load, hold_vld_next;

   assign is_load   = (ex_opcode_i == OP_LOAD);
   assign is_store  = (ex_opcode_i == OP_STORE);
   assign is_mem    = is_load | is_store;
   assign stall_o   = (state == ST_REQ) & ~dmem.ack;
   assign accept    = ex_valid_i & ~stall_o;
   assign xfer_done = (state == ST_REQ) & dmem.ack;
   assign tmo       = (state == ST_REQ) & ~dmem.ack & (cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign mem_fault = misalign | illegal;
   assign issue     = accept & is_mem & ~mem_fault;
   assign imm_vld   = accept & (~is_mem | mem_fault);

   mem_stage_lsu_align u_align (
      .is_store  (is_store),
      .funct3    (ex_funct3_i),
      .ea_lo     (ex_result_i[1:0]),
      .sdata     (ex_sdata_i),
      .be        (be),
      .wdata     (wdata),
      .misalign  (misalign),
      .illegal   (illegal),
      .ld_funct3 (pend_f3_p1),
      .ld_ea_lo  (pend_ea_lo_p1),
      .rdata     (dmem.rdata),
      .ld_data   (ld_data)
   );

   // Result of an op that completes without a transfer (ALU or faulting mem op)
   always_comb begin
      imm_res.wd = ex_wd_i;
      if (!is_mem) begin
         imm_res.wreg  = ex_wreg_i & (ex_wd_i != 5'd0);
         imm_res.wdata = ex_result_i;
         imm_res.fault = FAULT_NONE;
      end else begin
         imm_res.wreg  = 1'b0;
         imm_res.wdata = '0;
         imm_res.fault = illegal ? FAULT_FUNCT3 : FAULT_MISALIGN;
      end
   end

   // Result of the outstanding transfer, either acked or timed out
   always_comb begin
      mem_res.wd    = pend_wd_p1;
      mem_res.fault = tmo ? FAULT_TIMEOUT : FAULT_NONE;
      mem_res.wreg  = pend_load_p1 & ~tmo & pend_wreg_p1;
      mem_res.wdata = (pend_load_p1 & ~tmo) ? ld_data : '0;
   end

   // Writeback arbitration: a transfer finishing in the same cycle that an
   // immediate op is accepted wins the port; the later op waits one cycle in
   // the hold slot so program order is kept. The hold slot is only occupied
   // while IDLE, so it never coincides with a transfer completion.
   always_comb begin
      wb_load       = 1'b1;
      wb_next       = imm_res;
      hold_vld_next = 1'b0;
      hold_next     = imm_res;
      if (xfer_done | tmo) begin
         wb_next       = mem_res;
         hold_vld_next = imm_vld;
      end else if (hold_vld_p1) begin
         wb_next       = hold_p1;
         hold_vld_next = imm_vld;
      end else if (!imm_vld) begin
         wb_load = 1'b0;
      end
   end

   // Writeback output registers and hold slot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_valid_o  <= 1'b0;
         wb_wd_o     <= '0;
         wb_wreg_o   <= 1'b0;
         wb_wdata_o  <= '0;
         fault_o     <= FAULT_NONE;
         hold_vld_p1 <= 1'b0;
         hold_p1     <= '0;
      end else begin
         wb_valid_o  <= wb_load;
         hold_vld_p1 <= hold_vld_next;
         hold_p1     <= hold_next;
         if (wb_load) begin
            wb_wd_o    <= wb_next.wd;
            wb_wreg_o  <= wb_next.wreg;
            wb_wdata_o <= wb_next.wdata;
            fault_o    <= wb_next.fault;
         end else begin
            fault_o    <= FAULT_NONE;
         end
      end
   end

   // Transfer FSM, timeout counter and registered bus outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         dmem.req      <= 1'b0;
         dmem.we       <= 1'b0;
         dmem.addr     <= '0;
         dmem.be       <= '0;
         dmem.wdata    <= '0;
         pend_load_p1  <= 1'b0;
         pend_f3_p1    <= '0;
         pend_ea_lo_p1 <= '0;
         pend_wd_p1    <= '0;
         pend_wreg_p1  <= 1'b0;
      end else if (issue) begin
         state         <= ST_REQ;
         cnt           <= '0;
         dmem.req      <= 1'b1;
         dmem.we       <= is_store;
         dmem.addr     <= {ex_result_i[31:2], 2'b00};
         dmem.be       <= be;
         dmem.wdata    <= wdata;
         pend_load_p1  <= is_load;
         pend_f3_p1    <= ex_funct3_i;
         pend_ea_lo_p1 <= ex_result_i[1:0];
         pend_wd_p1    <= ex_wd_i;
         pend_wreg_p1  <= ex_wreg_i & (ex_wd_i != 5'd0);
      end else if (xfer_done | tmo) begin
         state    <= ST_IDLE;
         dmem.req <= 1'b0;
      end else if (state == ST_REQ) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule
